// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider.
// Provides the FSM state type, the default operand width and the
// iteration-counter width helper used by the top level.
package div_pkg;

    localparam int DIV_WIDTH = 8;

    // Counter must hold 0..w-1; a 1-bit floor keeps degenerate widths legal.
    function automatic int cnt_bits(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int DIV_CNT_W = cnt_bits(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIVIDE  = 2'd1,
        CORRECT = 2'd2
    } div_state_t;

endpackage

// File: rtl/signed_divider_if.sv
// Start-strobe handshake bundle for the signed divider.
//   valid/dividend/divisor : request from the master (start strobe + operands)
//   busy/done              : progress and one-cycle completion pulse
//   quotient/remainder     : registered results
//   div_by_zero/overflow   : registered status flags, valid with done
interface signed_divider_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic                    valid;
    logic signed [WIDTH-1:0] dividend;
    logic signed [WIDTH-1:0] divisor;
    logic                    busy;
    logic                    done;
    logic signed [WIDTH-1:0] quotient;
    logic signed [WIDTH-1:0] remainder;
    logic                    div_by_zero;
    logic                    overflow;

    modport master (
        output valid, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  valid, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes (combinational).
//   rem_i / rem_o : partial remainder, WIDTH+1 bits
//   quo_i / quo_o : quotient shift register, WIDTH bits
//   dvs_i         : divisor magnitude
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quo_o
);
    // One guard bit above the shifted remainder so the top bit is a true sign.
    logic [WIDTH+1:0] trial;
    logic             ge;

    assign trial = {rem_i, quo_i[WIDTH-1]} - {2'b00, dvs_i};
    assign ge    = ~trial[WIDTH+1];
    assign rem_o = ge ? trial[WIDTH:0] : {rem_i[WIDTH-1:0], quo_i[WIDTH-1]};
    assign quo_o = {quo_i[WIDTH-2:0], ge};
endmodule

// File: rtl/signed_divider.sv
// Sequential signed divider: one restoring step per clock on magnitudes,
// then sign correction into registered quotient/remainder with a done pulse.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : slave side of signed_divider_if (valid/operands in, results out)
//
// state   | meaning
// IDLE    | waiting for valid; accepts a new op in any IDLE cycle
// DIVIDE  | WIDTH restoring iterations, counter 0..WIDTH-1
// CORRECT | apply signs / special cases, load outputs, pulse done
module signed_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    signed_divider_if.slave  bus
);
    localparam int CNT_W = (WIDTH == DIV_WIDTH) ? DIV_CNT_W : cnt_bits(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             neg_dvd_q, neg_dvd_d;
    logic             neg_dvs_q, neg_dvs_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remd_q, remd_d;
    logic             done_q, done_d;
    logic             dz_flag_q, dz_flag_d;
    logic             ovf_flag_q, ovf_flag_d;

    logic [WIDTH:0]   rem_nx;
    logic [WIDTH-1:0] quo_nx;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (rem_nx),
        .quo_o (quo_nx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            neg_dvd_q  <= 1'b0;
            neg_dvs_q  <= 1'b0;
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
            quot_q     <= '0;
            remd_q     <= '0;
            done_q     <= 1'b0;
            dz_flag_q  <= 1'b0;
            ovf_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            neg_dvd_q  <= neg_dvd_d;
            neg_dvs_q  <= neg_dvs_d;
            zero_q     <= zero_d;
            ovf_q      <= ovf_d;
            quot_q     <= quot_d;
            remd_q     <= remd_d;
            done_q     <= done_d;
            dz_flag_q  <= dz_flag_d;
            ovf_flag_q <= ovf_flag_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        neg_dvd_d  = neg_dvd_q;
        neg_dvs_d  = neg_dvs_q;
        zero_d     = zero_q;
        ovf_d      = ovf_q;
        quot_d     = quot_q;
        remd_d     = remd_q;
        done_d     = 1'b0;
        dz_flag_d  = dz_flag_q;
        ovf_flag_d = ovf_flag_q;

        unique case (state_q)
            IDLE: begin
                if (bus.valid) begin
                    neg_dvd_d  = bus.dividend[WIDTH-1];
                    neg_dvs_d  = bus.divisor[WIDTH-1];
                    quo_d      = mag(bus.dividend);
                    dvs_d      = mag(bus.divisor);
                    rem_d      = '0;
                    cnt_d      = '0;
                    zero_d     = (bus.divisor == '0);
                    ovf_d      = ($unsigned(bus.dividend) == MOST_NEG) && (bus.divisor == '1);
                    dz_flag_d  = 1'b0;
                    ovf_flag_d = 1'b0;
                    state_d    = (bus.divisor == '0) ? CORRECT : DIVIDE;
                end
            end
            DIVIDE: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = CORRECT;
                end
            end
            CORRECT: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (zero_q) begin
                    // No iterations ran, so quo_q still holds |dividend|.
                    quot_d    = '1;
                    remd_d    = neg_dvd_q ? -quo_q : quo_q;
                    dz_flag_d = 1'b1;
                end else begin
                    // Most-negative / -1 wraps back to most-negative naturally.
                    quot_d     = (neg_dvd_q ^ neg_dvs_q) ? -quo_q : quo_q;
                    remd_d     = neg_dvd_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                    ovf_flag_d = ovf_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // done is issued from IDLE, so busy must be held through that cycle too.
    assign bus.busy        = (state_q != IDLE) || done_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = remd_q;
    assign bus.div_by_zero = dz_flag_q;
    assign bus.overflow    = ovf_flag_q;
endmodule

// File: tb/tb_signed_divider.sv
module tb_signed_divider;
    import div_pkg::*;

    localparam int W = 8;

    typedef struct {
        logic signed [W-1:0] q;
        logic signed [W-1:0] r;
        logic                dz;
        logic                ovf;
        int                  a;
        int                  b;
    } exp_t;

    exp_t sb[$];

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    signed_divider_if #(.WIDTH(W)) bus ();

    signed_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        exp_t e;
        int   qi;
        int   ri;
        e.a = int'(a);
        e.b = int'(b);
        if (b == 0) begin
            e.q   = '1;
            e.r   = a;
            e.dz  = 1'b1;
            e.ovf = 1'b0;
        end else begin
            qi    = int'(a) / int'(b);
            ri    = int'(a) % int'(b);
            e.q   = qi[W-1:0];
            e.r   = ri[W-1:0];
            e.dz  = 1'b0;
            e.ovf = (int'(a) == -128) && (int'(b) == -1);
        end
        return e;
    endfunction

    // Result monitor: every done pulse must match the oldest pending op.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.done === 1'b1) begin
            check("done_has_pending_op", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("quot %0d/%0d", e.a, e.b), bus.quotient, e.q);
                check($sformatf("rem %0d/%0d", e.a, e.b), bus.remainder, e.r);
                check($sformatf("dz %0d/%0d", e.a, e.b), 32'(bus.div_by_zero), 32'(e.dz));
                check($sformatf("ovf %0d/%0d", e.a, e.b), 32'(bus.overflow), 32'(e.ovf));
            end
        end
    end

    task automatic drive(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        bus.valid    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        sb.push_back(model(a, b));
    endtask

    task automatic accept();
        @(posedge clk);
        #1 bus.valid = 1'b0;
    endtask

    // Counts cycles from the accept edge to the done cycle (inclusive) and busy cycles.
    task automatic wait_done(input string tag, input int exp_lat);
        int n    = 0;
        int bsy  = 0;
        bit seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.busy === 1'b1) bsy++;
            if (bus.done === 1'b1) seen = 1'b1;
        end
        check({tag, " latency"}, seen ? n : -1, exp_lat);
        check({tag, " busy"}, bsy, exp_lat);
    endtask

    task automatic do_op(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                         input string tag);
        drive(a, b);
        accept();
        wait_done(tag, (b == 0) ? 2 : W + 2);
    endtask

    initial begin
        logic signed [W-1:0] specials [5];
        logic signed [W-1:0] ra;
        logic signed [W-1:0] rb;
        int n;
        int dones;
        int gap;

        specials = '{-8'sd128, -8'sd1, 8'sd0, 8'sd127, 8'sd1};

        rst_n        = 1'b0;
        bus.valid    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(bus.busy), 0);
        check("reset done", 32'(bus.done), 0);
        check("reset quot", bus.quotient, 0);
        check("reset rem", bus.remainder, 0);
        check("reset dz", 32'(bus.div_by_zero), 0);
        check("reset ovf", 32'(bus.overflow), 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(8'sd100, 8'sd7, "100/7");
        do_op(-8'sd100, 8'sd7, "-100/7");
        do_op(8'sd100, -8'sd7, "100/-7");
        do_op(-8'sd100, -8'sd7, "-100/-7");
        do_op(-8'sd128, -8'sd1, "-128/-1");
        do_op(-8'sd128, 8'sd1, "-128/1");
        do_op(8'sd5, 8'sd0, "5/0");

        // Flags clear on the accept edge of the next op.
        drive(8'sd9, 8'sd2);
        accept();
        check("dz cleared at accept", 32'(bus.div_by_zero), 0);
        wait_done("9/2", W + 2);

        // valid pulsed mid-operation must be ignored.
        drive(8'sd100, 8'sd7);
        accept();
        n = 0;
        dones = 0;
        while (dones == 0 && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 3) begin
                bus.valid    = 1'b1;
                bus.dividend = 8'sd50;
                bus.divisor  = 8'sd3;
            end else if (n == 4) begin
                bus.valid = 1'b0;
            end
            if (bus.done === 1'b1) dones++;
        end
        check("ignored valid latency", n, W + 2);
        repeat (12) @(negedge clk);
        check("ignored valid no extra op", 32'(sb.size()), 0);

        // Reset in the middle of an op.
        drive(8'sd100, 8'sd7);
        accept();
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("midrst quot", bus.quotient, 0);
        check("midrst rem", bus.remainder, 0);
        check("midrst busy", 32'(bus.busy), 0);
        check("midrst done", 32'(bus.done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (14) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        check("no done after reset", dones, 0);
        do_op(-8'sd77, 8'sd6, "-77/6 after reset");

        // Random ops, about half issued back-to-back in the done cycle.
        for (int i = 0; i < 1000; i++) begin
            ra  = ($urandom_range(0, 7) == 0) ? specials[$urandom_range(0, 4)]
                                              : W'($urandom_range(0, 255));
            rb  = ($urandom_range(0, 7) == 0) ? specials[$urandom_range(0, 4)]
                                              : W'($urandom_range(0, 255));
            gap = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
            repeat (gap) @(negedge clk);
            do_op(ra, rb, "rnd");
        end

        repeat (4) @(negedge clk);
        check("scoreboard drained", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
